// File: rtl/pc_sequencer.sv
// Program-sequencing controller: owns the PC, resolves jumps against latched
// ALU flags and produces the commit strobe from a run/step/halt state machine.
module pc_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_req,
    output logic              step_ack,
    input  logic              halt_op,
    input  logic              jump_en,
    input  logic [2:0]        jump_cond,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              flag_load,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    output logic [ADDR_W-1:0] pc,
    output logic              exec_en,
    output logic [2:0]        flags,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        WAIT   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t cur_state;
    state_t next_state;
    logic   exec_cycle;
    logic   cond_true;
    logic   flag_z;
    logic   flag_n;
    logic   flag_c;

    // Conditions look only at the latched flags, so a flag-setting jump sees the old values
    assign {flag_c, flag_n, flag_z} = flags;

    always_comb begin
        cond_true = 1'b0;
        case (jump_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z;
            3'b011:  cond_true = !flag_n && !flag_z;
            3'b100:  cond_true = !flag_n;
            3'b101:  cond_true = flag_n;
            3'b110:  cond_true = flag_n || flag_z;
            default: cond_true = flag_c;
        endcase
    end

    always_comb begin
        next_state = cur_state;
        exec_cycle = 1'b0;
        case (cur_state)
            IDLE: begin
                if (run)
                    next_state = RUN;
                else if (step_req)
                    next_state = STEP;
            end
            RUN: begin
                exec_cycle = 1'b1;
                if (halt_op)
                    next_state = HALTED;
                else if (!run)
                    next_state = IDLE;
            end
            STEP: begin
                exec_cycle = 1'b1;
                next_state = halt_op ? HALTED : WAIT;
            end
            WAIT: begin
                if (!step_req)
                    next_state = IDLE;
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // Masked by reset so the datapath cannot load in the cycle that is being aborted
    assign exec_en  = exec_cycle && !halt_op && !reset;
    assign step_ack = (cur_state == WAIT);
    assign halted   = (cur_state == HALTED);
    assign state    = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            pc        <= '0;
            flags     <= '0;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (exec_en) begin
                pc <= (jump_en && cond_true) ? jump_addr : pc + ADDR_W'(1);
                if (flag_load)
                    flags <= {alu_c, alu_n, alu_z};
                if (retired != {CNT_W{1'b1}})
                    retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed program scenarios plus random traffic, all
// checked every cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, step_req, halt_op, jump_en, flag_load;
    logic       alu_z, alu_n, alu_c;
    logic [2:0] jump_cond;
    logic [7:0] jump_addr;

    logic        step_ack, exec_en, halted;
    logic [7:0]  pc;
    logic [2:0]  flags, state;
    logic [15:0] retired;

    logic        step_ack4, exec_en4, halted4;
    logic [7:0]  pc4;
    logic [2:0]  flags4, state4;
    logic [3:0]  retired4;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Model state: mode uses the externally visible state numbers
    int       m_mode;
    int       m_pc;
    int       m_ret;
    bit [2:0] m_flags;

    pc_sequencer #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .step_ack(step_ack),
        .halt_op(halt_op), .jump_en(jump_en), .jump_cond(jump_cond), .jump_addr(jump_addr),
        .flag_load(flag_load), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .pc(pc), .exec_en(exec_en), .flags(flags), .halted(halted), .state(state),
        .retired(retired)
    );

    pc_sequencer #(.ADDR_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .step_req(step_req), .step_ack(step_ack4),
        .halt_op(halt_op), .jump_en(jump_en), .jump_cond(jump_cond), .jump_addr(jump_addr),
        .flag_load(flag_load), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .pc(pc4), .exec_en(exec_en4), .flags(flags4), .halted(halted4), .state(state4),
        .retired(retired4)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit condHolds(input bit [2:0] cond, input bit [2:0] f);
        bit z, n, c;
        z = f[0];
        n = f[1];
        c = f[2];
        case (cond)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return !n && !z;
            3'd4: return !n;
            3'd5: return n;
            3'd6: return n || z;
            default: return c;
        endcase
    endfunction

    function automatic bit modelExec();
        return (m_mode == 1 || m_mode == 2);
    endfunction

    task automatic modelStep();
        if (reset) begin
            m_mode  = 0;
            m_pc    = 0;
            m_ret   = 0;
            m_flags = 3'b000;
        end else if (modelExec() && halt_op) begin
            m_mode = 4;
        end else if (modelExec()) begin
            if (jump_en && condHolds(jump_cond, m_flags))
                m_pc = jump_addr;
            else
                m_pc = (m_pc + 1) % 256;
            if (flag_load)
                m_flags = {alu_c, alu_n, alu_z};
            m_ret++;
            m_mode = (m_mode == 2) ? 3 : (run ? 1 : 0);
        end else if (m_mode == 0) begin
            m_mode = run ? 1 : (step_req ? 2 : 0);
        end else if (m_mode == 3) begin
            m_mode = step_req ? 3 : 0;
        end
    endtask

    task automatic checkOutput();
        int exp_ret16, exp_ret4;
        exp_ret16 = (m_ret > 65535) ? 65535 : m_ret;
        exp_ret4  = (m_ret > 15) ? 15 : m_ret;
        checkVal("pc", pc, m_pc);
        checkVal("flags", flags, m_flags);
        checkVal("state", state, m_mode);
        checkVal("halted", halted, m_mode == 4);
        checkVal("step_ack", step_ack, m_mode == 3);
        checkVal("exec_en", exec_en, !reset && modelExec() && !halt_op);
        checkVal("retired", retired, exp_ret16);
        checkVal("retired4", retired4, exp_ret4);
        checkVal("pc4", pc4, m_pc);
        checkVal("exec_en4", exec_en4, exec_en);
    endtask

    always @(posedge clk) if (checking) modelStep();

    always @(negedge clk) begin
        #1;
        if (checking) checkOutput();
    end

    task automatic drive(input bit r, input bit rn, input bit sr, input bit h,
                         input bit je, input bit [2:0] jc, input bit [7:0] ja,
                         input bit fl, input bit z, input bit n, input bit c);
        reset = r; run = rn; step_req = sr; halt_op = h;
        jump_en = je; jump_cond = jc; jump_addr = ja;
        flag_load = fl; alu_z = z; alu_n = n; alu_c = c;
    endtask

    task automatic applyStimulus(input bit r, input bit rn, input bit sr, input bit h,
                                 input bit je, input bit [2:0] jc, input bit [7:0] ja,
                                 input bit fl, input bit z, input bit n, input bit c);
        drive(r, rn, sr, h, je, jc, ja, fl, z, n, c);
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        m_mode = 0; m_pc = 0; m_ret = 0; m_flags = 3'b000;
        checking = 1;
        @(negedge clk);
        #2;
        checkVal("reset pc", pc, 0);
        checkVal("reset state", state, 0);
        checkVal("reset retired", retired, 0);

        // Straight-line run, then CMP setting Z at pc=3 and JEQ 0x20 at pc=4
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("run entry state", state, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("pc after three", pc, 3);
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 3'd1, 8'h20, 0, 0, 0, 0);
        checkVal("jeq taken pc", pc, 8'h20);
        checkVal("retired five", retired, 5);
        checkVal("flags z", flags, 3'b001);
        applyStimulus(0, 1, 0, 0, 1, 3'd1, 8'h40, 1, 0, 0, 0);
        checkVal("jeq old z pc", pc, 8'h40);
        checkVal("flags cleared", flags, 0);
        applyStimulus(0, 1, 0, 0, 1, 3'd1, 8'h60, 0, 0, 0, 0);
        checkVal("jeq not taken pc", pc, 8'h41);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("run drop pc", pc, 8'h42);
        checkVal("run drop state", state, 0);

        // Single step with step_req held for six cycles
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("step ack high", step_ack, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("step still ack", step_ack, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("step one commit pc", pc, 8'h43);
        checkVal("step retired", retired, 9);
        checkVal("step back idle", state, 0);
        checkVal("step ack low", step_ack, 0);

        // Jump to 7, halt there, then ignore run/step until reset
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'h07, 0, 0, 0, 0);
        checkVal("jump always pc", pc, 7);
        drive(0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        #1;
        checkVal("halt exec_en", exec_en, 0);
        @(negedge clk);
        checkVal("halted high", halted, 1);
        checkVal("halted pc", pc, 7);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("halted sticky", state, 4);
        checkVal("halted pc hold", pc, 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("halt reset pc", pc, 0);
        checkVal("halt reset halted", halted, 0);

        // PC wrap with a non-taken jump at 0xFF
        applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'hFF, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 3'd1, 8'h10, 0, 0, 0, 0);
        checkVal("wrap pc", pc, 0);
        checkVal("wrap retired", retired, 2);

        // Reset mid-RUN
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("rst run state", state, 0);
        checkVal("rst run retired", retired, 0);
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        #1;
        checkVal("rst run exec_en", exec_en, 0);
        @(negedge clk);

        // Reset mid-WAIT
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("in wait", state, 3);
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("rst wait state", state, 0);
        checkVal("rst wait ack", step_ack, 0);
        checkVal("rst wait pc", pc, 0);

        // Saturation of the narrow counter build
        for (int i = 0; i < 21; i++) applyStimulus(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        checkVal("wide retired 20", retired, 20);
        checkVal("narrow retired sat", retired4, 15);

        // Random traffic
        begin
            bit rn, sr;
            rn = 0;
            sr = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) rn = ~rn;
                if ($urandom_range(3) == 0) sr = ~sr;
                applyStimulus($urandom_range(63) == 0, rn, sr, $urandom_range(31) == 0,
                              1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
                              1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-sequencing controller for the single-cycle 8-bit computer. It owns the program counter feeding instruction memory and resolves conditional and unconditional jumps against latched ALU status flags. A run/single-step/halt state machine produces the commit strobe that gates register loads (LA/LB) in the datapath. It sits between the control unit, the ALU and the instruction memory, replacing the free-running PC.

## Interface
Parameters:
- ADDR_W, 8, program-counter / instruction-address width
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; free-run execution while high
- step_req  in  1  single-step request, four-phase handshake with step_ack
- step_ack  out  1  single-step acknowledge
- halt_op  in  1  from control unit: current instruction is HALT
- jump_en  in  1  from control unit: current instruction is a jump
- jump_cond  in  3  condition code, see Operation
- jump_addr  in  ADDR_W  jump target (instruction literal k8)
- flag_load  in  1  from control unit: current instruction updates flags
- alu_z, alu_n, alu_c  in  1 each  zero / negative (bit 7) / carry-out of current ALU result
- pc  out  ADDR_W  program counter to instruction memory
- exec_en  out  1  commit strobe; datapath loads are ANDed with it
- flags  out  3  latched {C,N,Z}
- halted  out  1  high in HALTED state
- state  out  3  FSM state encoding, for waveform/debug
- retired  out  CNT_W  instructions committed since reset, saturating

## Operation
- States: IDLE=0, RUN=1, STEP=2, WAIT=3, HALTED=4.
- IDLE: run=1 -> RUN; else step_req=1 -> STEP; else stay. run has priority over step_req.
- RUN: executes one instruction per cycle; run=0 sampled -> IDLE after the current cycle's commit.
- STEP: executes exactly one instruction -> WAIT.
- WAIT: step_ack=1; step_req=0 -> IDLE; else stay. No execution.
- HALTED: exited only by reset; run and step_req ignored.
- Exec cycle: state is RUN or STEP. exec_en = exec cycle AND NOT halt_op; it is combinational from state and halt_op.
- halt_op in an exec cycle: pc, flags and retired hold; next state HALTED, regardless of run and step_req.
- Commit (exec_en=1):
  - Next pc: jump_addr if jump_en AND cond true, else pc+1 modulo 2^ADDR_W. 0xFF+1 wraps to 0x00 with no side effect.
  - flags <= {alu_c, alu_n, alu_z} if flag_load.
  - retired increments, saturating at 2^CNT_W-1.
- Conditions evaluate the latched flags register, never the live ALU flags:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 !N&!Z
  - 100 !N
  - 101 N
  - 110 N|Z
  - 111 C
- Jump and flag_load in the same instruction: the condition uses the old flags, and the flags still update.
- Outside exec cycles, pc, flags and retired hold.

## Timing
- Reset (synchronous, wins over everything):
  - pc=0, flags=0, retired=0, state=IDLE
  - exec_en=0, step_ack=0, halted=0
  - Reset mid-RUN or mid-WAIT aborts on that edge. No commit occurs in the reset cycle.
- pc, flags and retired update on the same edge that the datapath registers load. Instruction memory is combinational from pc.
- Run latency:
  - run rising while in IDLE: the first exec cycle is the next cycle.
  - run falling while in RUN: one more instruction commits, then IDLE.
- Step handshake: step_req high in IDLE -> STEP next cycle (one commit) -> WAIT, with step_ack high from the following cycle. step_ack drops in the cycle after step_req is seen low.
- Holding step_req high yields exactly one commit.
- halted and state are registered; halted rises the cycle after halt_op commits.

## Test plan
- Reset, then run=1 over program 0x00..0x04 with no jumps -> pc sequence 0,1,2,3,4; exec_en=1 each cycle; retired=5 after five commits.
- CMP producing Z=1 (flag_load) at pc=3, then JEQ (cond 001, jump_addr=0x20) at pc=4 -> pc=0x20. The same test with Z=0 -> pc=5. A same-instruction flag_load+JEQ uses the old Z.
- IDLE, step_req held high for 6 cycles -> exactly one commit; pc 0->1; step_ack high from cycle 2 until one cycle after step_req falls; state returns to IDLE.
- halt_op at pc=7 during RUN -> exec_en=0 that cycle, pc stays 7, halted=1 next cycle; run and step_req are then ignored until reset; reset -> pc=0, halted=0.
- pc=0xFF with a non-taken jump -> pc=0x00. retired preloaded near the limit (CNT_W=4 build) -> saturates at 15.
- Reset asserted in WAIT and in RUN -> all outputs at reset values next cycle; no commit in the reset cycle.
